// File: rtl/ppg_pkg.sv
// Shared widths, FSM encoding and helpers for the PPG peak detector.
package ppg_pkg;

  localparam int SAMPLE_W = 20;
  localparam int PERIOD_W = 12;
  localparam int AVG_TAPS = 4;
  localparam int AVG_SH   = 2;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [PERIOD_W-1:0] period_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } state_e;

  typedef struct packed {
    period_t period;
    sample_t peak;
    sample_t valley;
    sample_t ac;
  } beat_t;

  function automatic sample_t sat_sub(sample_t a, sample_t b);
    return (a > b) ? sample_t'(a - b) : '0;
  endfunction

  function automatic period_t sat_inc(period_t v);
    return (&v) ? v : period_t'(v + period_t'(1));
  endfunction

endpackage

// File: rtl/ppg_peak_detect_if.sv
// Sample stream in, beat report out, between the FIR stage and
// the peak detector.
interface ppg_peak_detect_if;
  import ppg_pkg::*;

  sample_t In_Filtered;
  logic    In_Valid;
  logic    Beat_Valid;
  period_t Beat_Period;
  sample_t Peak_Value;
  sample_t Valley_Value;
  sample_t AC_Amplitude;
  period_t Avg_Period;
  logic    Timeout;

  modport master (
    output In_Filtered,
    output In_Valid,
    input  Beat_Valid,
    input  Beat_Period,
    input  Peak_Value,
    input  Valley_Value,
    input  AC_Amplitude,
    input  Avg_Period,
    input  Timeout
  );

  modport slave (
    input  In_Filtered,
    input  In_Valid,
    output Beat_Valid,
    output Beat_Period,
    output Peak_Value,
    output Valley_Value,
    output AC_Amplitude,
    output Avg_Period,
    output Timeout
  );

endinterface

// File: rtl/ppg_period_avg.sv
// 4-tap running mean of accepted beat periods; only built when
// PPG_AVG_PERIOD_EN is defined.
`ifdef PPG_AVG_PERIOD_EN
module ppg_period_avg
  import ppg_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr_i,
  input  logic    upd_i,
  input  period_t period_i,
  output period_t avg_o
);

  period_t hist_q [AVG_TAPS];
  period_t hist_d [AVG_TAPS];
  logic    full_q, full_d;
  period_t avg_q, avg_d;

  logic [PERIOD_W+AVG_SH-1:0] sum;

  always_comb begin
    sum = {{AVG_SH{1'b0}}, period_i};
    for (int i = 0; i < AVG_TAPS-1; i++) begin
      sum = sum + {{AVG_SH{1'b0}}, hist_q[i]};
    end
  end

  // an empty history is primed with the first period so the
  // mean never averages in stale zeros
  always_comb begin
    hist_d = hist_q;
    full_d = full_q;
    avg_d  = avg_q;
    unique case (1'b1)
      clr_i: begin
        for (int i = 0; i < AVG_TAPS; i++) begin
          hist_d[i] = '0;
        end
        full_d = 1'b0;
      end
      upd_i && !full_q: begin
        for (int i = 0; i < AVG_TAPS; i++) begin
          hist_d[i] = period_i;
        end
        full_d = 1'b1;
        avg_d  = period_i;
      end
      upd_i && full_q: begin
        hist_d[0] = period_i;
        for (int i = 1; i < AVG_TAPS; i++) begin
          hist_d[i] = hist_q[i-1];
        end
        avg_d = sum[PERIOD_W+AVG_SH-1:AVG_SH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_TAPS; i++) begin
        hist_q[i] <= '0;
      end
      full_q <= 1'b0;
      avg_q  <= '0;
    end else begin
      hist_q <= hist_d;
      full_q <= full_d;
      avg_q  <= avg_d;
    end
  end

  assign avg_o = avg_q;

endmodule
`endif

// File: rtl/ppg_peak_detect.sv
// Hysteresis peak/valley beat detector for filtered PPG samples.
// PPG_AVG_PERIOD_EN adds a 4-beat averaged period output.
module ppg_peak_detect
  import ppg_pkg::*;
#(
  parameter int HYST       = 256,
  parameter int MIN_PERIOD = 100,
  parameter int MAX_PERIOD = 1500
) (
  input  logic             CLK_Filter,
  input  logic             rst_n,
  ppg_peak_detect_if.slave bus
);

  localparam logic [SAMPLE_W:0] HYST_W = (SAMPLE_W+1)'(HYST);
  localparam logic [PERIOD_W:0] MIN_W  = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0] MAX_W  = (PERIOD_W+1)'(MAX_PERIOD);

  state_e  state_q, state_d;
  period_t cnt_q, cnt_d;
  logic    has_peak_q, has_peak_d;
  sample_t run_max_q, run_max_d;
  sample_t run_min_q, run_min_d;
  sample_t valley_q, valley_d;
  beat_t   beat_q, beat_d;
  logic    beat_valid_q, beat_valid_d;
  logic    timeout_q, timeout_d;

  sample_t           smp;
  logic              vld;
  logic [PERIOD_W:0] len;
  logic              peak_hit, valley_hit;
  logic              accept, first_pk, tmo;

  assign smp = bus.In_Filtered;
  assign vld = bus.In_Valid;
  assign len = {1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};

  // 21-bit compares so sample+HYST cannot wrap
  assign peak_hit = vld && (state_q == RISING) &&
                    (({1'b0, smp} + HYST_W) < {1'b0, run_max_q});
  assign valley_hit = vld && (state_q == FALLING) &&
                      ({1'b0, smp} > ({1'b0, run_min_q} + HYST_W));

  assign accept   = peak_hit && has_peak_q && (len >= MIN_W);
  assign tmo      = vld && !accept && (len == MAX_W);
  assign first_pk = peak_hit && !has_peak_q && !tmo;

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (vld) begin
      unique case (state_q)
        IDLE:    state_d = RISING;
        RISING:  if (peak_hit) state_d = FALLING;
        FALLING: if (valley_hit) state_d = RISING;
        default: state_d = IDLE;
      endcase
    end
    if (tmo) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    has_peak_d   = has_peak_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    valley_d     = valley_q;
    beat_d       = beat_q;
    beat_valid_d = accept;
    timeout_d    = tmo;

    // rejected short peaks fall through and keep counting
    unique case (1'b1)
      !vld: ;
      tmo: begin
        cnt_d      = '0;
        has_peak_d = 1'b0;
      end
      accept: begin
        cnt_d  = '0;
        beat_d = '{period: sat_inc(cnt_q),
                   peak:   run_max_q,
                   valley: valley_q,
                   ac:     sat_sub(run_max_q, valley_q)};
      end
      first_pk: begin
        cnt_d      = '0;
        has_peak_d = 1'b1;
      end
      default: cnt_d = sat_inc(cnt_q);
    endcase

    if (vld) begin
      unique case (state_q)
        IDLE: begin
          run_max_d = smp;
          run_min_d = smp;
        end
        RISING: begin
          if (peak_hit) begin
            run_min_d = smp;
          end else if (smp > run_max_q) begin
            run_max_d = smp;
          end
        end
        FALLING: begin
          if (valley_hit) begin
            valley_d  = run_min_q;
            run_max_d = smp;
          end else if (smp < run_min_q) begin
            run_min_d = smp;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      has_peak_q   <= 1'b0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      valley_q     <= '0;
      beat_q       <= '0;
      beat_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      has_peak_q   <= has_peak_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      valley_q     <= valley_d;
      beat_q       <= beat_d;
      beat_valid_q <= beat_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.Beat_Valid   = beat_valid_q;
  assign bus.Beat_Period  = beat_q.period;
  assign bus.Peak_Value   = beat_q.peak;
  assign bus.Valley_Value = beat_q.valley;
  assign bus.AC_Amplitude = beat_q.ac;
  assign bus.Timeout      = timeout_q;

`ifdef PPG_AVG_PERIOD_EN
  period_t avg;

  ppg_period_avg u_avg (
    .clk      (CLK_Filter),
    .rst_n    (rst_n),
    .clr_i    (tmo),
    .upd_i    (accept),
    .period_i (sat_inc(cnt_q)),
    .avg_o    (avg)
  );

  assign bus.Avg_Period = avg;
`else
  assign bus.Avg_Period = beat_q.period;
`endif

endmodule

// File: tb/tb_ppg_peak_detect.sv
// Directed bench for ppg_peak_detect: block-wave table, triangle,
// spurious peak, strobed input, timeout and reset sequences.
module tb_ppg_peak_detect;
  import ppg_pkg::*;

  typedef struct {
    int hi_len;
    int lo_len;
    int hi_val;
    int lo_val;
    int bv;
    int per;
    int pk;
    int vl;
    int ac;
    int avg_on;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   beats = 0;
  int   touts = 0;

  always #5 clk = ~clk;

  ppg_peak_detect_if bus ();

  ppg_peak_detect #(
    .HYST       (256),
    .MIN_PERIOD (100),
    .MAX_PERIOD (1500)
  ) dut (
    .CLK_Filter (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_avg(input int avg_on, input int per);
`ifdef PPG_AVG_PERIOD_EN
    return avg_on;
`else
    return per;
`endif
  endfunction

  task automatic step(input int val, input bit v);
    @(negedge clk);
    bus.In_Filtered = 20'(val);
    bus.In_Valid    = v;
    @(posedge clk);
    #1;
    if (bus.Beat_Valid) beats++;
    if (bus.Timeout) touts++;
  endtask

  task automatic chk_out(input string tag, input int bv, input int to,
                         input int per, input int pk, input int vl,
                         input int ac, input int avg);
    chk({tag, ".beat_valid"}, int'(bus.Beat_Valid), bv);
    chk({tag, ".timeout"}, int'(bus.Timeout), to);
    chk({tag, ".period"}, int'(bus.Beat_Period), per);
    chk({tag, ".peak"}, int'(bus.Peak_Value), pk);
    chk({tag, ".valley"}, int'(bus.Valley_Value), vl);
    chk({tag, ".ac"}, int'(bus.AC_Amplitude), ac);
    chk({tag, ".avg"}, int'(bus.Avg_Period), avg);
  endtask

  // hi block, one confirming lo sample (checked), rest of lo block
  task automatic apply_rec(input rec_t r, input string tag);
    int b0;
    b0 = beats;
    repeat (r.hi_len) step(r.hi_val, 1'b1);
    chk({tag, ".no_early_beat"}, beats - b0, 0);
    step(r.lo_val, 1'b1);
    chk_out(tag, r.bv, 0, r.per, r.pk, r.vl, r.ac,
            exp_avg(r.avg_on, r.per));
    repeat (r.lo_len - 1) step(r.lo_val, 1'b1);
  endtask

  function automatic int tri_v(input int n);
    int p;
    p = n % 500;
    return (p <= 250) ? 40 * p : 40 * (500 - p);
  endfunction

  function automatic int spur_v(input int k);
    if (k <= 20) return 5000;
    if (k <= 59) return 6000;
    if (k == 60) return 5000;
    if (k <= 100) return 0;
    if (k <= 250) return 1000;
    if (k <= 499) return 10000;
    return 0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rec_t tb_b[8];
    rec_t tb_e[3];
    int   b0;
    int   t0;

    tb_b[0] = '{200, 200, 10000, 0, 0, 0, 0, 0, 0, 0};
    tb_b[1] = '{200, 200, 10000, 0, 1, 400, 10000, 0, 10000, 400};
    tb_b[2] = '{200, 200, 1048575, 1000, 1, 400, 1048575, 0,
                1048575, 400};
    tb_b[3] = '{200, 300, 50000, 40000, 1, 400, 50000, 1000,
                49000, 400};
    tb_b[4] = '{300, 1, 40257, 40000, 1, 600, 40257, 40000, 257, 450};
    tb_b[5] = '{98, 51, 60000, 0, 0, 600, 40257, 40000, 257, 450};
    tb_b[6] = '{50, 1, 20000, 5000, 1, 200, 20000, 0, 20000, 400};
    tb_b[7] = '{99, 1, 30000, 0, 1, 100, 30000, 5000, 25000, 325};

    tb_e[0] = '{150, 150, 10000, 0, 0, 500, 10000, 0, 10000, 500};
    tb_e[1] = '{150, 1, 10000, 0, 1, 300, 10000, 0, 10000, 300};
    tb_e[2] = '{1499, 1, 10000, 0, 1, 1500, 10000, 0, 10000, 600};

    bus.In_Filtered = '0;
    bus.In_Valid    = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) step(0, 1'b0);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // block waveform table: periods, boundaries, averaging
    for (int i = 0; i < 8; i++) begin
      apply_rec(tb_b[i], $sformatf("blk%0d", i));
    end

    // reset lands on a sample that would otherwise be accepted
    repeat (150) step(10000, 1'b1);
    rst_n = 1'b0;
    step(0, 1'b1);
    chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1'b1);
    step(0, 1'b1);
    rst_n = 1'b1;

    // triangle: first peak silent, second peak is a 500 beat
    b0 = beats;
    for (int n = 0; n <= 757; n++) begin
      step(tri_v(n), 1'b1);
      if (n == 257) chk("tri.first_peak", int'(bus.Beat_Valid), 0);
    end
    chk_out("tri.beat", 1, 0, 500, 10000, 0, 10000, 500);
    chk("tri.count", beats - b0, 1);

    // spurious peak 60 samples after an accepted one
    b0 = beats;
    for (int k = 1; k <= 500; k++) begin
      step(spur_v(k), 1'b1);
      if (k == 60) chk("spur.reject", int'(bus.Beat_Valid), 0);
    end
    chk_out("spur.beat", 1, 0, 500, 10000, 0, 10000, 500);
    chk("spur.count", beats - b0, 1);

    // reset, then the triangle on every third cycle
    rst_n = 1'b0;
    repeat (3) step(0, 1'b0);
    chk_out("rst2", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    b0 = beats;
    for (int n = 0; n <= 757; n++) begin
      step(tri_v(n), 1'b1);
      if (n == 257) chk("tri3.first_peak", int'(bus.Beat_Valid), 0);
      if (n == 757) chk_out("tri3.beat", 1, 0, 500, 10000, 0, 10000, 500);
      step(0, 1'b0);
      if (n == 757) begin
        chk("tri3.pulse_end", int'(bus.Beat_Valid), 0);
        chk("tri3.hold", int'(bus.Beat_Period), 500);
      end
      step(0, 1'b0);
    end
    chk("tri3.count", beats - b0, 1);

    // flat signal with ripple: periodic timeout, no beats
    b0 = beats;
    t0 = touts;
    for (int j = 1; j <= 3000; j++) begin
      step((j % 2 == 1) ? 5100 : 4900, 1'b1);
      if (j == 1499) chk("tmo.before", int'(bus.Timeout), 0);
      if (j == 1500) chk("tmo.first", int'(bus.Timeout), 1);
      if (j == 1501) chk("tmo.pulse_end", int'(bus.Timeout), 0);
      if (j == 3000) chk("tmo.second", int'(bus.Timeout), 1);
    end
    chk("tmo.count", touts - t0, 2);
    chk("tmo.no_beat", beats - b0, 0);

    // recovery after timeout, then peak coinciding with timeout
    for (int i = 0; i < 3; i++) begin
      apply_rec(tb_e[i], $sformatf("post%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ppg_peak_detect.md
PPG_PEAK_DETECT -- requirements
Module: ppg_peak_detect

Interface
REQ-001 Parameter HYST, default 256, hysteresis in LSBs for peak/valley confirmation.
REQ-002 Parameter MIN_PERIOD, default 100, minimum accepted beat period in valid samples (300 bpm at 500 Hz).
REQ-003 Parameter MAX_PERIOD, default 1500, valid samples without an accepted peak before timeout (3 s).
REQ-004 CLK_Filter  in  1  filter clock; one clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 In_Filtered  in  20  unsigned filtered PPG sample from the upstream FIR stage.
REQ-007 In_Valid  in  1  one-cycle strobe qualifying In_Filtered.
REQ-008 Beat_Valid  out  1  one-cycle pulse; beat outputs updated this cycle.
REQ-009 Beat_Period  out  12  valid samples between the last two accepted peaks.
REQ-010 Peak_Value / Valley_Value  out  20 each  confirmed peak and preceding confirmed valley.
REQ-011 AC_Amplitude  out  20  Peak_Value minus Valley_Value.
REQ-012 Avg_Period  out  12  averaged period (see Configuration).
REQ-013 Timeout  out  1  one-cycle pulse on loss of pulse signal.

Function
REQ-014 FSM states IDLE, RISING, FALLING; sample-driven transitions happen only on In_Valid=1; cycles with In_Valid=0 change no state, counter or tracker.
REQ-015 IDLE: on a valid sample, load run_max=run_min=sample, go RISING.
REQ-016 RISING: run_max=max(run_max,sample); peak confirmed when sample+HYST < run_max (21-bit compare, strict); then go FALLING, run_min=sample.
REQ-017 FALLING: run_min=min(run_min,sample); valley confirmed when sample > run_min+HYST (21-bit, strict); latch valley=run_min, go RISING, run_max=sample.
REQ-018 Period counter cnt (12 bit) increments per valid sample, saturating at 4095; counting starts at reset release.
REQ-019 At peak confirmation, len=cnt+1; accepted if has_peak=1 and len>=MIN_PERIOD -> Beat_Valid next cycle with Beat_Period=len, Peak_Value=run_max, Valley_Value=latched valley, AC_Amplitude=difference saturated at 0.
REQ-020 First peak after reset/timeout (has_peak=0): no beat, set has_peak, cnt<=0.
REQ-021 Peak with len<MIN_PERIOD: rejected, no beat, cnt not cleared, FSM still goes FALLING.
REQ-022 Accepted peak: cnt<=0.
REQ-023 If cnt+1==MAX_PERIOD on a valid sample without accepted peak: Timeout next cycle, cnt<=0, has_peak<=0, FSM->IDLE.
REQ-024 Accepted peak and timeout on same sample: peak wins, no Timeout.
REQ-025 Latency: outputs registered; Beat_Valid/Timeout exactly one cycle after the confirming In_Valid cycle; beat outputs hold between beats.

Reset
REQ-026 rst_n=0 at a clock edge: all outputs 0, FSM IDLE, cnt=0, has_peak=0, trackers and average history 0; mid-operation reset discards any pending beat.

Configuration
REQ-027 Macro PPG_AVG_PERIOD_EN defined: Avg_Period = sum of last 4 accepted Beat_Period >>2, updated with Beat_Valid; first beat after reset/timeout fills all 4 slots with that period; timeout clears history.
REQ-028 Macro undefined: Avg_Period equals Beat_Period; no history storage.

Structure
REQ-029 Package ppg_pkg holds SAMPLE_W=20, PERIOD_W=12, state enum (IDLE/RISING/FALLING).
REQ-030 Sub-module ppg_period_avg implements the 4-tap average, instantiated only with PPG_AVG_PERIOD_EN.

Verification
REQ-031 rst_n low 3 cycles mid-stream -> all outputs 0 the next cycle, first beat requires two new peaks.
REQ-032 Triangle 0->10000->0, period 500 valid samples, HYST 256 -> no beat at first peak; second peak Beat_Period=500, Peak 10000, Valley 0, AC 10000.
REQ-033 Constant 5000 plus ripple ±100 -> no Beat_Valid; Timeout pulse at valid sample 1500, repeats every 1500.
REQ-034 Accepted peak, spurious peak 60 samples later, next peak 500 after accepted -> no beat at 60; beat with Beat_Period=500.
REQ-035 Same triangle with In_Valid every 3rd cycle -> Beat_Period=500, Beat_Valid one cycle after confirming strobe.
REQ-036 PPG_AVG_PERIOD_EN, periods 400,400,400,600 -> Avg_Period 400,400,400,450; macro off -> Avg_Period tracks Beat_Period.
